// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor, one GROUP-bit look-ahead group resolved per stage.
// Valid/ready flow control with per-stage ready so bubbles collapse under back-pressure.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned NSTG = WIDTH / GROUP;

    generate
        if ((WIDTH % GROUP) != 0) begin : g_bad_param
            $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    // Stage registers: stage k holds groups 0..k resolved and the carry into group k+1
    logic [NSTG-1:0]            v_q;
    logic [NSTG-1:0]            c_q;
    logic [NSTG-1:0]            am_q;
    logic [NSTG-1:0]            bm_q;
    logic [NSTG-1:0][WIDTH-1:0] a_q;
    logic [NSTG-1:0][WIDTH-1:0] b_q;
    logic [NSTG-1:0][WIDTH-1:0] s_q;
    logic                       ovf_q;

    // Per-stage sources (input beat for stage 0, previous stage otherwise)
    logic [NSTG-1:0]            src_v;
    logic [NSTG-1:0]            src_c;
    logic [NSTG-1:0]            src_am;
    logic [NSTG-1:0]            src_bm;
    logic [NSTG-1:0][WIDTH-1:0] src_a;
    logic [NSTG-1:0][WIDTH-1:0] src_b;
    logic [NSTG-1:0][WIDTH-1:0] src_s;
    logic [NSTG-1:0][WIDTH-1:0] nxt_s;
    logic [NSTG-1:0]            nxt_c;

    logic [WIDTH-1:0]           b_in;
    logic                       ci_in;
    logic [GROUP-1:0]           grp_p;
    logic [GROUP-1:0]           grp_g;
    logic [GROUP:0]             grp_c;
    logic [NSTG:0]              rdy;

    // Flat sum-of-products look-ahead: every carry is a direct function of p, g and ci
    function automatic logic [GROUP:0] cla_carry(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             ci);
        logic [GROUP:0] c;
        logic           t;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= int'(GROUP); i++) begin
            t = ci;
            for (int m = 0; m < i; m++) t = t & p[m];
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return c;
    endfunction

    always_comb begin
        b_in   = in_sub ? ~in_b : in_b;
        ci_in  = in_sub | in_cin;
        src_v  = '0;
        src_c  = '0;
        src_am = '0;
        src_bm = '0;
        src_a  = '0;
        src_b  = '0;
        src_s  = '0;
        nxt_s  = '0;
        nxt_c  = '0;
        grp_p  = '0;
        grp_g  = '0;
        grp_c  = '0;

        src_v[0]  = in_valid;
        src_c[0]  = ci_in;
        src_am[0] = in_a[WIDTH-1];
        src_bm[0] = b_in[WIDTH-1];
        src_a[0]  = in_a;
        src_b[0]  = b_in;
        for (int k = 1; k < int'(NSTG); k++) begin
            src_v[k]  = v_q[k-1];
            src_c[k]  = c_q[k-1];
            src_am[k] = am_q[k-1];
            src_bm[k] = bm_q[k-1];
            src_a[k]  = a_q[k-1];
            src_b[k]  = b_q[k-1];
            src_s[k]  = s_q[k-1];
        end

        for (int k = 0; k < int'(NSTG); k++) begin
            grp_p    = src_a[k][k*GROUP +: GROUP] ^ src_b[k][k*GROUP +: GROUP];
            grp_g    = src_a[k][k*GROUP +: GROUP] & src_b[k][k*GROUP +: GROUP];
            grp_c    = cla_carry(grp_p, grp_g, src_c[k]);
            nxt_s[k] = src_s[k];
            nxt_s[k][k*GROUP +: GROUP] = grp_p ^ grp_c[GROUP-1:0];
            nxt_c[k] = grp_c[GROUP];
        end
    end

    // A stage may load when it is empty or its successor is loading
    always_comb begin
        rdy       = '0;
        rdy[NSTG] = out_ready;
        for (int k = int'(NSTG) - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] | rdy[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NSTG); k++) begin
                if (rdy[k]) begin
                    v_q[k]  <= src_v[k];
                    c_q[k]  <= nxt_c[k];
                    am_q[k] <= src_am[k];
                    bm_q[k] <= src_bm[k];
                    a_q[k]  <= src_a[k];
                    b_q[k]  <= src_b[k];
                    s_q[k]  <= nxt_s[k];
                end
            end
            if (rdy[NSTG-1]) begin
                ovf_q <= (src_am[NSTG-1] == src_bm[NSTG-1]) &
                         (nxt_s[NSTG-1][WIDTH-1] != src_am[NSTG-1]);
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NSTG-1];
    assign out_sum   = s_q[NSTG-1];
    assign out_cout  = c_q[NSTG-1];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector and scoreboard bench for cla_pipe_adder (WIDTH=16, GROUP=4, latency 4).
module tb_cla_pipe_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned GROUP = 4;
    localparam int          NSTG  = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    // Reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] r;
        logic        ov;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
        ov = (a[15] == bb[15]) && (r[15] != a[15]);
        return {ov, r};
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_sub   = v.sub;
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(NSTG));
        check({name, "_sum"},  32'(out_sum),  32'(v.sum));
        check({name, "_cout"}, 32'(out_cout), 32'(v.cout));
        check({name, "_ovf"},  32'(out_ovf),  32'(v.ovf));
    endtask

    logic [17:0] q[$];
    logic [17:0] exp_r;
    logic [17:0] held;
    logic        prev_hold;
    int          sent;
    int          got;
    int          iter;

    initial begin
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_cout",  32'(out_cout),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream, no back-pressure
        @(negedge clk);
        sent = 0; got = 0; iter = 0;
        while (got < 100 && iter < 300) begin
            if (iter > 0) @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 100);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_cin    = 1'($urandom);
            in_sub    = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                exp_r = q.pop_front();
                check("stream_beat", 32'({out_ovf, out_cout, out_sum}), 32'(exp_r));
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_cin, in_sub));
                sent++;
            end
            iter++;
        end
        check("stream_count",  32'(got),  32'd100);
        check("stream_cycles", 32'(iter), 32'd104);

        // Random back-pressure
        prev_hold = 1'b0;
        held      = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_cin    = 1'($urandom);
            in_sub    = 1'($urandom);
            #1;
            if (prev_hold) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", 32'({out_ovf, out_cout, out_sum}), 32'(held));
            end
            check("bp_in_ready", 32'(in_ready),
                  32'(!(q.size() == NSTG && !out_ready)));
            prev_hold = out_valid && !out_ready;
            held      = {out_ovf, out_cout, out_sum};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("bp_extra_beat", 32'd1, 32'd0);
                end else begin
                    exp_r = q.pop_front();
                    check("bp_beat", 32'({out_ovf, out_cout, out_sum}), 32'(exp_r));
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub));
        end
        iter = 0;
        while (q.size() > 0 && iter < 50) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                exp_r = q.pop_front();
                check("drain_beat", 32'({out_ovf, out_cout, out_sum}), 32'(exp_r));
            end
            iter++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
        #1;
        check("drain_no_extra", 32'(out_valid), 32'd0);

        // Reset with three beats in flight, plus a beat offered during reset
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'(n + 1);
            in_b     = 16'h0100;
            in_sub   = 1'b0;
            in_cin   = 1'b0;
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 16'h5555;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_sum",      32'(out_sum),  32'd0);
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            check($sformatf("mid_rst_quiet%0d", n), 32'(out_valid), 32'd0);
        end
        run_vec(vecs[1], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
